// File: rtl/vcache_stat_sequencer.sv
// vcache_stat_sequencer: buffers print-stat requests from the stat-write path and
// broadcasts them to every vcache profiler as one-cycle print_stat_v/print_stat_tag
// pulses. A forced gap after each pulse lets each CSV dump finish. The block also
// owns the free-running global cycle counter that the profilers log.
//
// Ports:
//   clk_i             clock
//   reset_n_i         synchronous active-low reset
//   v_i, tag_i        stat request and its tag
//   ready_o           request buffer can accept (registered ~full)
//   print_stat_v_o    one-cycle print pulse
//   print_stat_tag_o  tag qualified by print_stat_v_o, held between pulses
//   global_ctr_o      free-running cycle count
//   busy_o            buffer non-empty or sequencer not idle
//   dropped_o         sticky: a request arrived while ready_o was low
//   print_stat_ts_o   enqueue timestamp of the issued tag
//
// Optional feature macro: VCACHE_STAT_SEQ_TIMESTAMP_EN stores global_ctr_o with
// each buffered request and presents it on print_stat_ts_o. Without it the
// output is tied to zero.

module vcache_stat_sequencer #(
   parameter int unsigned data_width_p = 32,
   parameter int unsigned ctr_width_p  = 32,
   parameter int unsigned fifo_els_p   = 4,
   parameter int unsigned gap_cycles_p = 2
) (
   input  logic                    clk_i,
   input  logic                    reset_n_i,
   input  logic                    v_i,
   input  logic [data_width_p-1:0] tag_i,
   output logic                    ready_o,
   output logic                    print_stat_v_o,
   output logic [data_width_p-1:0] print_stat_tag_o,
   output logic [ctr_width_p-1:0]  global_ctr_o,
   output logic                    busy_o,
   output logic                    dropped_o,
   output logic [ctr_width_p-1:0]  print_stat_ts_o
);

   localparam int unsigned addr_w_lp = $clog2(fifo_els_p);
   localparam int unsigned ptr_w_lp  = addr_w_lp + 1;
   localparam int unsigned gap_w_lp  = (gap_cycles_p > 1) ? $clog2(gap_cycles_p) : 1;

   typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_e;

   state_e                  state_r;
   logic [gap_w_lp-1:0]     gap_cnt_r;
   logic [ptr_w_lp-1:0]     wr_ptr_r;
   logic [ptr_w_lp-1:0]     rd_ptr_r;
   logic [data_width_p-1:0] tag_mem [fifo_els_p];

   logic                    enq_c;
   logic                    deq_c;
   logic                    load_c;
   logic [ptr_w_lp-1:0]     rd_ptr_p1_c;
   logic [ptr_w_lp-1:0]     occ_c;
   logic [ptr_w_lp-1:0]     occ_nxt_c;
   logic [addr_w_lp-1:0]    load_addr_c;

   // Buffer bookkeeping; the extra pointer bit separates full from empty.
   assign enq_c       = v_i & ready_o;
   assign deq_c       = (state_r == ISSUE);
   assign rd_ptr_p1_c = rd_ptr_r + ptr_w_lp'(1);
   assign occ_c       = wr_ptr_r - rd_ptr_r;
   assign occ_nxt_c   = occ_c + ptr_w_lp'(enq_c) - ptr_w_lp'(deq_c);

   // A new pulse is loaded from IDLE with a waiting entry, or straight from ISSUE
   // when there is no gap and an entry sits behind the one being dequeued.
   assign load_c = ((state_r == IDLE) && (occ_c != '0)) ||
                   ((gap_cycles_p == 0) && (state_r == ISSUE) && (occ_c > ptr_w_lp'(1)));
   assign load_addr_c = (state_r == ISSUE) ? rd_ptr_p1_c[addr_w_lp-1:0]
                                           : rd_ptr_r[addr_w_lp-1:0];

   // Free-running global cycle counter, wraps silently.
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) global_ctr_o <= '0;
      else            global_ctr_o <= global_ctr_o + ctr_width_p'(1);
   end

   // Pointers, ready and the sticky drop flag.
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         wr_ptr_r  <= '0;
         rd_ptr_r  <= '0;
         ready_o   <= 1'b1;
         dropped_o <= 1'b0;
      end else begin
         if (enq_c) wr_ptr_r <= wr_ptr_r + ptr_w_lp'(1);
         if (deq_c) rd_ptr_r <= rd_ptr_p1_c;
         ready_o <= (occ_nxt_c != ptr_w_lp'(fifo_els_p));
         if (v_i && !ready_o) dropped_o <= 1'b1;
      end
   end

   // Tag storage needs no reset: entries are only read after being written.
   always_ff @(posedge clk_i) begin
      if (enq_c) tag_mem[wr_ptr_r[addr_w_lp-1:0]] <= tag_i;
   end

   // Sequencer FSM: one ISSUE cycle per entry followed by the forced gap.
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_r        <= IDLE;
         gap_cnt_r      <= '0;
         print_stat_v_o <= 1'b0;
         busy_o         <= 1'b0;
      end else begin
         print_stat_v_o <= load_c;
         case (state_r)
            IDLE: begin
               if (occ_c != '0) state_r <= ISSUE;
               busy_o <= (occ_nxt_c != '0);
            end
            ISSUE: begin
               if (gap_cycles_p != 0) begin
                  state_r   <= GAP;
                  gap_cnt_r <= gap_w_lp'(gap_cycles_p - 1);
                  busy_o    <= 1'b1;
               end else begin
                  state_r <= load_c ? ISSUE : IDLE;
                  busy_o  <= (occ_nxt_c != '0);
               end
            end
            GAP: begin
               if (gap_cnt_r == '0) begin
                  state_r <= IDLE;
                  busy_o  <= (occ_nxt_c != '0);
               end else begin
                  gap_cnt_r <= gap_cnt_r - gap_w_lp'(1);
                  busy_o    <= 1'b1;
               end
            end
            default: begin
               state_r <= IDLE;
               busy_o  <= (occ_nxt_c != '0);
            end
         endcase
      end
   end

   // Issued tag, held between pulses.
   always_ff @(posedge clk_i) begin
      if (!reset_n_i)  print_stat_tag_o <= '0;
      else if (load_c) print_stat_tag_o <= tag_mem[load_addr_c];
   end

`ifdef VCACHE_STAT_SEQ_TIMESTAMP_EN
   logic [ctr_width_p-1:0] ts_mem [fifo_els_p];

   // Enqueue-time counter value travels with each entry.
   always_ff @(posedge clk_i) begin
      if (enq_c) ts_mem[wr_ptr_r[addr_w_lp-1:0]] <= global_ctr_o;
   end

   always_ff @(posedge clk_i) begin
      if (!reset_n_i)  print_stat_ts_o <= '0;
      else if (load_c) print_stat_ts_o <= ts_mem[load_addr_c];
   end
`else
   assign print_stat_ts_o = '0;
`endif

endmodule
